step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 Parameter PULSE_HI, default 50, sysclk cycles PU is held high per step.
REQ-002 Parameter PULSE_LO, default 50, sysclk cycles PU is held low after each step.
REQ-003 Parameter MAX_POS, default 999, highest legal coordinate.
REQ-004 sysclk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 home_start  in  1  one-cycle pulse; starts homing of all six motors.
REQ-007 Stop  in  6  limit switches, bit i high = motor i at zero stop.
REQ-008 cmd_valid  in  1  move command present.
REQ-009 cmd_ready  out  1  command accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-010 cmd_motor  in  3  target motor 0..5.
REQ-011 cmd_target  in  10  target coordinate, binary.
REQ-012 cmd_err  out  1  one-cycle pulse: command rejected.
REQ-013 PU  out  6  step pulses, one-hot or zero.
REQ-014 DR  out  6  direction; 1 = increasing coordinate.
REQ-015 MF  out  6  motor free; 1 = de-energised.
REQ-016 homed  out  1  all six motors calibrated.
REQ-017 busy  out  1  homing in progress or any move pending.
REQ-018 done  out  1  one-cycle pulse when busy falls.

Function
REQ-019 States: IDLE, HOME_STEP, HOME_GAP, ARB, STEP_HI, STEP_LO.
REQ-020 A single shared step timer serves all motors; at most one PU bit is high in any cycle.
REQ-021 home_start in IDLE enters homing with motor index 0; home_start in any other state is ignored.
REQ-022 Homing for motor i: DR[i]=0, MF[i]=0, issue steps until Stop[i] is sampled high at the start of a step; then pos[i]=0 and advance to i+1; after motor 5, homed=1 and return to IDLE.
REQ-023 cmd_ready = homed and state is not a homing state.
REQ-024 An accepted command with cmd_motor>5 or cmd_target>MAX_POS is dropped and pulses cmd_err on the following cycle.
REQ-025 A valid command writes target[m] and sets pending[m] when target differs from pos[m]; when equal, no step is issued.
REQ-026 A command to a motor that is already pending overwrites its target; the new target takes effect at that motor's next arbitration.
REQ-027 ARB selects the lowest pending index strictly greater than the last served index, wrapping 5->0 (round-robin).
REQ-028 For the selected motor: DR = (target > pos); PU high for exactly PULSE_HI cycles, then low for PULSE_LO cycles; pos is incremented or decremented by 1 on the cycle PU falls.
REQ-029 When pos equals target after the update, pending is cleared.
REQ-030 If Stop[m] is high when a decreasing step is selected, no pulse is issued, pos[m]=0, pending[m] is cleared, and cmd_err pulses.
REQ-031 MF[i]=1 until motor i is homed, then 0.
REQ-032 busy is high in homing states and while any pending bit is set; done pulses for one cycle on busy falling.

Reset
REQ-033 On sysclk with rst_n=0: state IDLE, PU=0, DR=0, MF=6'b111111, homed=0, busy=0, done=0, cmd_err=0, all pending bits 0, all pos and target 0, last served index 5.
REQ-034 Reset asserted mid-step drops PU in the same edge; no partial step is counted.

Structure
REQ-035 A shared package holds the state encoding, the motor count (6), the coordinate width (10), and the default PULSE_HI/PULSE_LO/MAX_POS values.
REQ-036 One sub-module, step_timer, produces the high/low phase timing and a phase-complete strobe; arbitration and position tracking stay in step_scheduler.

Verification
REQ-037 Homing: home_start, Stop[i] raised after 3+i steps of motor i -> pulse counts 3,4,5,6,7,8 in order on PU[0..5], homed=1, MF=0, done pulse.
REQ-038 Single move: command motor 5 target 11 -> exactly 11 PU[5] pulses, DR[5]=1, each 50 high/50 low cycles, then target 8 -> 3 pulses with DR[5]=0.
REQ-039 Round-robin: commands motor 1 target 2 and motor 4 target 2 in consecutive cycles -> pulse order 1,4,1,4, never two PU bits high.
REQ-040 Errors: cmd_motor=6 or cmd_target=1000 -> cmd_err one cycle, no pulses; command before homing -> cmd_ready=0, no acceptance.
REQ-041 Boundaries: target equal to pos -> no pulse, busy stays 0; retarget of pending motor 2 from 20 to 5 at pos 10 -> DR[2] flips, stops at 5.
REQ-042 Reset during STEP_HI -> PU=0 next edge, pos unchanged, homed=0, MF=6'b111111.

Source files
------------

// File: rtl/step_scheduler_pkg.sv
// Shared types and constants for the six-axis step scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package step_scheduler_pkg;

    localparam int NUM_MOTORS   = 6;
    localparam int COORD_W      = 10;
    localparam int IDX_W        = 3;
    localparam int DEF_PULSE_HI = 50;
    localparam int DEF_PULSE_LO = 50;
    localparam int DEF_MAX_POS  = 999;

    typedef enum logic [2:0] {
        IDLE,
        HOME_STEP,
        HOME_GAP,
        ARB,
        STEP_HI,
        STEP_LO
    } state_t;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // Round-robin pick: first requesting index after 'last', wrapping.
    // Scans farthest-first so the nearest requester is the final assignment.
    // Returns 'last' when nothing requests; callers gate on |req.
    function automatic idx_t rr_pick(input logic [NUM_MOTORS-1:0] req, input idx_t last);
        idx_t pick;
        int   j;
        pick = last;
        for (int k = NUM_MOTORS; k >= 1; k--) begin
            j = (int'(last) + k) % NUM_MOTORS;
            if (req[j]) begin
                pick = idx_t'(j);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Shared step timer: one high phase of PULSE_HI cycles, then a low phase.
// Latency: phase_done strobes on the last cycle of each phase; start is taken when idle.
// Backpressure: none; the caller only pulses start while the timer is idle.
//
// Ports: clk/rst_n (sync, active-low), start (begin a step), active (a phase
// is running), phase_done (last cycle of the current phase).
//
// The low phase runs PULSE_LO-1 cycles: the scheduler spends one more low
// cycle deciding what to step next, so PU stays low exactly PULSE_LO cycles
// between consecutive steps. PULSE_LO must therefore be at least 2.
module step_timer #(
    parameter int PULSE_HI = 50,
    parameter int PULSE_LO = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic active,
    output logic phase_done
);

    localparam int CNT_MAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_hi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= 1'b0;
            phase_hi <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            active   <= 1'b1;
            phase_hi <= 1'b1;
            cnt      <= CNT_W'(PULSE_HI - 1);
        end else if (active) begin
            if (cnt == '0) begin
                if (phase_hi) begin
                    phase_hi <= 1'b0;
                    cnt      <= CNT_W'(PULSE_LO - 2);
                end else begin
                    active <= 1'b0;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign phase_done = active && (cnt == '0);

endmodule

// File: rtl/step_scheduler.sv
// Homes six stepper motors, then serves move commands round-robin on one step timer.
// Latency: command to first PU edge 2 cycles from IDLE; cmd_err one cycle after the bad command.
// Backpressure: cmd_ready low until homed and throughout homing; commands otherwise accepted every cycle.
//
// Ports: sysclk/rst_n (sync, active-low); home_start pulse; Stop[5:0] zero-stop
// switches; cmd_valid/cmd_ready/cmd_motor/cmd_target move command; cmd_err
// reject pulse; PU step pulses (one-hot or zero); DR direction (1 = up);
// MF motor free; homed, busy, done status.
module step_scheduler
    import step_scheduler_pkg::*;
#(
    parameter int PULSE_HI = DEF_PULSE_HI,
    parameter int PULSE_LO = DEF_PULSE_LO,
    parameter int MAX_POS  = DEF_MAX_POS
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  home_start,
    input  logic [NUM_MOTORS-1:0] Stop,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [IDX_W-1:0]      cmd_motor,
    input  logic [COORD_W-1:0]    cmd_target,
    output logic                  cmd_err,
    output logic [NUM_MOTORS-1:0] PU,
    output logic [NUM_MOTORS-1:0] DR,
    output logic [NUM_MOTORS-1:0] MF,
    output logic                  homed,
    output logic                  busy,
    output logic                  done
);

    localparam logic [NUM_MOTORS-1:0] MOTOR_ONE = NUM_MOTORS'(1);

    state_t                state, state_nxt;
    coord_t                pos    [NUM_MOTORS];
    coord_t                target [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] pending;
    logic [NUM_MOTORS-1:0] homed_mask;
    logic [NUM_MOTORS-1:0] dr_q;
    idx_t                  cur, last, home_idx, pick;
    logic                  pick_dec;
    logic                  homing;
    logic                  busy_q, cmd_err_q;
    logic                  accept, cmd_bad;
    logic                  tmr_start, tmr_active, tmr_done;
    logic                  home_hit, arb_go, arb_stop, step_commit;

    step_timer #(
        .PULSE_HI (PULSE_HI),
        .PULSE_LO (PULSE_LO)
    ) u_timer (
        .clk        (sysclk),
        .rst_n      (rst_n),
        .start      (tmr_start),
        .active     (tmr_active),
        .phase_done (tmr_done)
    );

    // A motor is pending whenever its target differs from its position, so a
    // retarget onto the current position cancels the move without extra state.
    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            pending[i] = (target[i] != pos[i]);
        end
    end

    assign pick     = rr_pick(pending, last);
    assign pick_dec = (target[pick] < pos[pick]);
    assign homing   = (state == HOME_STEP) || (state == HOME_GAP);

    assign cmd_ready = homed && !homing;
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_bad   = (cmd_motor > idx_t'(NUM_MOTORS - 1)) || (cmd_target > coord_t'(MAX_POS));

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmr_start   = 1'b0;
        home_hit    = 1'b0;
        arb_go      = 1'b0;
        arb_stop    = 1'b0;
        step_commit = 1'b0;
        case (state)
            IDLE: begin
                if (home_start) begin
                    state_nxt = HOME_GAP;
                end else if (|pending) begin
                    state_nxt = ARB;
                end
            end
            // Once the gap has elapsed, the switch is sampled before each step.
            HOME_GAP: begin
                if (!tmr_active) begin
                    if (Stop[home_idx]) begin
                        home_hit = 1'b1;
                        if (home_idx == idx_t'(NUM_MOTORS - 1)) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tmr_start = 1'b1;
                        state_nxt = HOME_STEP;
                    end
                end
            end
            HOME_STEP: begin
                if (tmr_done) begin
                    state_nxt = HOME_GAP;
                end
            end
            ARB: begin
                if (!(|pending)) begin
                    state_nxt = IDLE;
                end else if (pick_dec && Stop[pick]) begin
                    arb_stop = 1'b1;
                end else begin
                    arb_go    = 1'b1;
                    tmr_start = 1'b1;
                    state_nxt = STEP_HI;
                end
            end
            STEP_HI: begin
                if (tmr_done) begin
                    step_commit = 1'b1;
                    state_nxt   = STEP_LO;
                end
            end
            STEP_LO: begin
                if (tmr_done) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Commands are applied last so a same-cycle command wins over FSM writes.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                pos[i]    <= '0;
                target[i] <= '0;
            end
            homed_mask <= '0;
            dr_q       <= '0;
            cur        <= '0;
            last       <= idx_t'(NUM_MOTORS - 1);
            home_idx   <= '0;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            busy_q    <= busy;
            cmd_err_q <= (accept && cmd_bad) || arb_stop;

            if ((state == IDLE) && home_start) begin
                home_idx   <= '0;
                homed_mask <= '0;
            end

            if (state == HOME_GAP) begin
                dr_q[home_idx] <= 1'b0;
            end

            if (home_hit) begin
                pos[home_idx]        <= '0;
                target[home_idx]     <= '0;
                homed_mask[home_idx] <= 1'b1;
                home_idx             <= home_idx + idx_t'(1);
            end

            if (arb_go) begin
                cur        <= pick;
                last       <= pick;
                dr_q[pick] <= (target[pick] > pos[pick]);
            end

            // Switch already closed on a downward move: snap to zero, drop the move.
            if (arb_stop) begin
                pos[pick]    <= '0;
                target[pick] <= '0;
                last         <= pick;
            end

            if (step_commit) begin
                pos[cur] <= dr_q[cur] ? (pos[cur] + coord_t'(1)) : (pos[cur] - coord_t'(1));
            end

            if (accept && !cmd_bad) begin
                target[cmd_motor] <= cmd_target;
            end
        end
    end

    always_comb begin
        PU = '0;
        if (state == HOME_STEP) begin
            PU = MOTOR_ONE << home_idx;
        end else if (state == STEP_HI) begin
            PU = MOTOR_ONE << cur;
        end
    end

    assign DR      = dr_q;
    assign MF      = ~homed_mask & ~(homing ? (MOTOR_ONE << home_idx) : '0);
    assign homed   = &homed_mask;
    assign busy    = homing || (|pending);
    assign done    = busy_q && !busy;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_step_scheduler.sv
`timescale 1ns/1ps
module tb_step_scheduler;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       home_start;
    logic [5:0] Stop;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_motor;
    logic [9:0] cmd_target;
    logic       cmd_err;
    logic [5:0] PU, DR, MF;
    logic       homed, busy, done;

    always #5 sysclk = ~sysclk;

    step_scheduler dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .home_start (home_start),
        .Stop       (Stop),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_motor  (cmd_motor),
        .cmd_target (cmd_target),
        .cmd_err    (cmd_err),
        .PU         (PU),
        .DR         (DR),
        .MF         (MF),
        .homed      (homed),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int m;
        int dir;
    } step_t;

    step_t exp_q[$];
    step_t mon_e;

    int total = 0;
    int bad   = 0;

    int  rise_cnt [6];
    int  fall_cnt [6];
    int  hi_len, low_len, last_m;
    int  multi_cnt, unexp_cnt, done_cnt, err_cnt, err_cyc;
    bit  busy_cont, mon_en, err_prev;
    logic [5:0] pu_prev;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_steps(input int m, input int dir, input int n);
        step_t s;
        s.m   = m;
        s.dir = dir;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(s);
        end
    endtask

    // Pulse monitor: pops the scoreboard on each PU rising edge and checks
    // pulse widths, the inter-step gap within a burst, and one-hotness.
    always @(negedge sysclk) begin
        if (mon_en) begin
            if ($countones(PU) > 1) multi_cnt++;
            if (done) done_cnt++;
            if (cmd_err) err_cyc++;
            if (cmd_err && !err_prev) err_cnt++;
            for (int m = 0; m < 6; m++) begin
                if (PU[m] && !pu_prev[m]) begin
                    rise_cnt[m]++;
                    if (exp_q.size() == 0) begin
                        unexp_cnt++;
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("pu_motor", m, mon_e.m);
                        chk("pu_dir", int'(DR[m]), mon_e.dir);
                    end
                    if (busy_cont && (homed || m == last_m)) chk("pu_lo_width", low_len, 50);
                    hi_len = 0;
                end
                if (!PU[m] && pu_prev[m]) begin
                    fall_cnt[m]++;
                    chk("pu_hi_width", hi_len, 50);
                    last_m    = m;
                    low_len   = 0;
                    busy_cont = 1'b1;
                end
            end
            if (PU != 6'd0) begin
                hi_len++;
            end else begin
                low_len++;
                if (!busy) busy_cont = 1'b0;
            end
            pu_prev  = PU;
            err_prev = cmd_err;
        end
    end

    task automatic send_cmd(input int m, input int t);
        int n;
        n = 0;
        @(negedge sysclk);
        cmd_valid  = 1'b1;
        cmd_motor  = 3'(m);
        cmd_target = 10'(t);
        while (!cmd_ready && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        chk("cmd_ready_wait", int'(cmd_ready), 1);
        @(posedge sysclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge sysclk);
        while (busy && n < 20000) begin
            @(negedge sysclk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic wait_falls(input int m, input int target_n);
        int n;
        n = 0;
        while (fall_cnt[m] < target_n && n < 5000) begin
            @(negedge sysclk);
            n++;
        end
        chk("fall_timeout", fall_cnt[m], target_n);
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int d0, e0, c0, r0, n, busy_seen;

        for (int i = 0; i < 6; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        hi_len = 0; low_len = 0; last_m = -1;
        multi_cnt = 0; unexp_cnt = 0; done_cnt = 0; err_cnt = 0; err_cyc = 0;
        busy_cont = 1'b0; mon_en = 1'b0; err_prev = 1'b0; pu_prev = 6'd0;

        rst_n = 1'b0; home_start = 1'b0; Stop = 6'd0;
        cmd_valid = 1'b0; cmd_motor = 3'd0; cmd_target = 10'd0;

        // Reset state
        repeat (3) @(negedge sysclk);
        chk("rst_pu", int'(PU), 0);
        chk("rst_dr", int'(DR), 0);
        chk("rst_mf", int'(MF), 63);
        chk("rst_homed", int'(homed), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(cmd_err), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Command before homing is never accepted
        @(negedge sysclk);
        cmd_valid = 1'b1; cmd_motor = 3'd0; cmd_target = 10'd5;
        repeat (5) @(negedge sysclk);
        chk("unhomed_ready", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("unhomed_busy", int'(busy), 0);

        // Homing: motor i sees its switch after 3+i steps
        for (int i = 0; i < 6; i++) push_steps(i, 0, 3 + i);
        d0 = done_cnt;
        @(negedge sysclk);
        home_start = 1'b1;
        @(negedge sysclk);
        home_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_falls(i, 3 + i);
            Stop[i] = 1'b1;
        end
        wait_idle();
        chk("home_homed", int'(homed), 1);
        chk("home_mf", int'(MF), 0);
        chk("home_done", done_cnt - d0, 1);
        for (int i = 0; i < 6; i++) chk("home_count", rise_cnt[i], 3 + i);
        chk("home_sb", exp_q.size(), 0);
        Stop = 6'd0;

        // Single move up 11, then down to 8
        push_steps(5, 1, 11);
        r0 = rise_cnt[5]; d0 = done_cnt;
        send_cmd(5, 11);
        wait_idle();
        chk("move_up_n", rise_cnt[5] - r0, 11);
        chk("move_up_done", done_cnt - d0, 1);
        chk("move_dr_up", int'(DR[5]), 1);
        push_steps(5, 0, 3);
        r0 = rise_cnt[5];
        send_cmd(5, 8);
        wait_idle();
        chk("move_dn_n", rise_cnt[5] - r0, 3);
        chk("move_dr_dn", int'(DR[5]), 0);

        // Rejected commands
        e0 = err_cnt; c0 = err_cyc; r0 = rise_cnt[0];
        send_cmd(6, 5);
        repeat (3) @(negedge sysclk);
        send_cmd(0, 1000);
        repeat (4) @(negedge sysclk);
        chk("err_pulses", err_cnt - e0, 2);
        chk("err_cycles", err_cyc - c0, 2);
        chk("err_busy", int'(busy), 0);
        chk("err_no_pulse", rise_cnt[0] - r0, 0);

        // Target equal to position: nothing happens
        d0 = done_cnt; busy_seen = 0;
        send_cmd(3, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge sysclk);
            if (busy) busy_seen++;
        end
        chk("eq_busy", busy_seen, 0);
        chk("eq_done", done_cnt - d0, 0);

        // Round-robin between motors 1 and 4
        exp_q.push_back('{1, 1}); exp_q.push_back('{4, 1});
        exp_q.push_back('{1, 1}); exp_q.push_back('{4, 1});
        send_cmd(1, 2);
        send_cmd(4, 2);
        wait_idle();
        chk("rr_sb", exp_q.size(), 0);

        // Retarget a pending motor mid-move
        push_steps(2, 1, 10);
        send_cmd(2, 10);
        wait_idle();
        push_steps(2, 1, 1);
        r0 = rise_cnt[2];
        send_cmd(2, 20);
        n = 0;
        while (rise_cnt[2] == r0 && n < 500) begin
            @(negedge sysclk);
            n++;
        end
        chk("retarget_start", rise_cnt[2] - r0, 1);
        push_steps(2, 0, 6);
        send_cmd(2, 5);
        wait_idle();
        chk("retarget_n", rise_cnt[2] - r0, 7);
        chk("retarget_dr", int'(DR[2]), 0);

        // Closed switch on a downward move: snap to zero, reject, no pulse
        push_steps(0, 1, 5);
        send_cmd(0, 5);
        wait_idle();
        @(negedge sysclk);
        Stop[0] = 1'b1;
        e0 = err_cnt; r0 = rise_cnt[0];
        send_cmd(0, 2);
        wait_idle();
        chk("stop_err", err_cnt - e0, 1);
        chk("stop_no_pulse", rise_cnt[0] - r0, 0);
        Stop[0] = 1'b0;
        push_steps(0, 1, 1);
        send_cmd(0, 1);
        wait_idle();
        chk("stop_pos_zero", rise_cnt[0] - r0, 1);

        chk("pu_onehot", multi_cnt, 0);
        chk("pu_unexpected", unexp_cnt, 0);
        chk("sb_left", exp_q.size(), 0);

        // Reset in the middle of a high phase
        @(negedge sysclk);
        mon_en = 1'b0;
        send_cmd(0, 4);
        n = 0;
        while (!PU[0] && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        chk("mid_pu_high", int'(PU[0]), 1);
        repeat (10) @(negedge sysclk);
        rst_n = 1'b0;
        @(posedge sysclk);
        #1;
        chk("mid_rst_pu", int'(PU), 0);
        chk("mid_rst_homed", int'(homed), 0);
        chk("mid_rst_mf", int'(MF), 63);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);
        chk("post_rst_pu", int'(PU), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_ready", int'(cmd_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
